// File: rtl/axi4l_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4l_gpio_slave
// Purpose  : AXI4-Lite responder exposing a small GPIO register bank.
//            Word offsets: 0x00 DOUT (RW), 0x04 DIR (RW), 0x08 DIN (RO,
//            2-flop synchronised gpio_in), 0x0C IER / 0x10 ISR (interrupt
//            build only). Decode uses address bits [addr_width-1:2].
// Options  : GPIO_IRQ_EN - adds IER/ISR, rising-edge detect and the irq port.
// Ports    : clk, rst (async, active-low)
//            AW*/W*/B*  write address / data / response channels
//            AR*/R*     read address / data channels
//            gpio_in    asynchronous pin inputs
//            gpio_out   pin output values (DOUT)
//            gpio_oe    per-pin output enable, 1 = drive (DIR)
//            irq        level interrupt, |(ISR & IER), registered
// Revision : 1.0 - initial release
// ============================================================================
module axi4l_gpio_slave #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int GPIO_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [addr_width-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [data_width-1:0]     WDATA,
    input  logic [data_width/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [addr_width-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [data_width-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic [GPIO_WIDTH-1:0]     gpio_in,
    output logic [GPIO_WIDTH-1:0]     gpio_out,
    output logic [GPIO_WIDTH-1:0]     gpio_oe
`ifdef GPIO_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int IW = addr_width - 2;
    localparam int SW = data_width / 8;

    localparam logic [IW-1:0] c_idx_dout = IW'(0);
    localparam logic [IW-1:0] c_idx_dir  = IW'(1);
    localparam logic [IW-1:0] c_idx_din  = IW'(2);
`ifdef GPIO_IRQ_EN
    localparam logic [IW-1:0] c_idx_ier  = IW'(3);
    localparam logic [IW-1:0] c_idx_isr  = IW'(4);
`endif
    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    // Ready outputs stay low until the first edge after reset release.
    logic                  r_rdy;
    logic                  r_aw_full;
    logic [IW-1:0]         r_aw_idx;
    logic                  r_w_full;
    logic [data_width-1:0] r_w_data;
    logic [SW-1:0]         r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [data_width-1:0] r_rdata;
    logic [GPIO_WIDTH-1:0] r_dout;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_sync1;
    logic [GPIO_WIDTH-1:0] r_sync2;

    logic                  w_aw_acc;
    logic                  w_w_acc;
    logic                  w_commit;
    logic [IW-1:0]         w_wr_idx;
    logic [data_width-1:0] w_wr_data;
    logic [SW-1:0]         w_wr_strb;
    logic [data_width-1:0] w_bmask;
    logic [data_width-1:0] w_wdm;
    logic [data_width-1:0] w_dout_ext;
    logic [data_width-1:0] w_dir_ext;
    logic [data_width-1:0] w_din_ext;
    logic [data_width-1:0] w_dout_new;
    logic [data_width-1:0] w_dir_new;
    logic                  w_wr_err;
    logic [data_width-1:0] w_rd_data;
    logic                  w_rd_err;

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_sync3;
    logic [GPIO_WIDTH-1:0] r_ier;
    logic [GPIO_WIDTH-1:0] r_isr;
    logic                  r_irq;
    logic [data_width-1:0] w_ier_ext;
    logic [data_width-1:0] w_isr_ext;
    logic [data_width-1:0] w_ier_new;
    logic [GPIO_WIDTH-1:0] w_isr_clr;
    logic [GPIO_WIDTH-1:0] w_rise;
`endif

    assign AWREADY  = r_rdy & ~r_aw_full;
    assign WREADY   = r_rdy & ~r_w_full;
    assign ARREADY  = r_rdy & ~r_rvalid;
    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign RVALID   = r_rvalid;
    assign RRESP    = r_rresp;
    assign RDATA    = r_rdata;
    assign gpio_out = r_dout;
    assign gpio_oe  = r_dir;

    assign w_aw_acc = AWVALID & AWREADY;
    assign w_w_acc  = WVALID & WREADY;
    // A beat arriving this cycle counts as "held", so a same-cycle AW+W
    // commits on the accepting edge without a trip through the holders.
    assign w_commit = (r_aw_full | w_aw_acc) & (r_w_full | w_w_acc) & ~r_bvalid;

    assign w_wr_idx  = r_aw_full ? r_aw_idx : AWADDR[addr_width-1:2];
    assign w_wr_data = r_w_full  ? r_w_data : WDATA;
    assign w_wr_strb = r_w_full  ? r_w_strb : WSTRB;

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < SW; b++) begin
            w_bmask[b*8 +: 8] = {8{w_wr_strb[b]}};
        end
        w_dout_ext = '0;
        w_dir_ext  = '0;
        w_din_ext  = '0;
        w_dout_ext[GPIO_WIDTH-1:0] = r_dout;
        w_dir_ext[GPIO_WIDTH-1:0]  = r_dir;
        w_din_ext[GPIO_WIDTH-1:0]  = r_sync2;
        w_wdm      = w_wr_data & w_bmask;
        w_dout_new = (w_dout_ext & ~w_bmask) | w_wdm;
        w_dir_new  = (w_dir_ext & ~w_bmask) | w_wdm;
    end

    // Write decode: DIN is read-only, so a write to it is an error.
    always_comb begin
        w_wr_err = 1'b1;
        if (w_wr_idx == c_idx_dout || w_wr_idx == c_idx_dir) w_wr_err = 1'b0;
`ifdef GPIO_IRQ_EN
        if (w_wr_idx == c_idx_ier || w_wr_idx == c_idx_isr) w_wr_err = 1'b0;
`endif
    end

    // Read mux sees register values before any same-edge write commit.
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (ARADDR[addr_width-1:2])
            c_idx_dout: w_rd_data = w_dout_ext;
            c_idx_dir:  w_rd_data = w_dir_ext;
            c_idx_din:  w_rd_data = w_din_ext;
`ifdef GPIO_IRQ_EN
            c_idx_ier:  w_rd_data = w_ier_ext;
            c_idx_isr:  w_rd_data = w_isr_ext;
`endif
            default:    w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy     <= 1'b0;
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_okay;
            r_rdata   <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? c_slverr : c_okay;
            end else begin
                if (w_aw_acc) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= AWADDR[addr_width-1:2];
                end
                if (w_w_acc) begin
                    r_w_full <= 1'b1;
                    r_w_data <= WDATA;
                    r_w_strb <= WSTRB;
                end
                if (r_bvalid && BREADY) r_bvalid <= 1'b0;
            end
            if (ARVALID && ARREADY) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_err ? c_slverr : c_okay;
            end else if (r_rvalid && RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout  <= '0;
            r_dir   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_commit && w_wr_idx == c_idx_dout) r_dout <= w_dout_new[GPIO_WIDTH-1:0];
            if (w_commit && w_wr_idx == c_idx_dir)  r_dir  <= w_dir_new[GPIO_WIDTH-1:0];
        end
    end

`ifdef GPIO_IRQ_EN
    always_comb begin
        w_ier_ext = '0;
        w_isr_ext = '0;
        w_ier_ext[GPIO_WIDTH-1:0] = r_ier;
        w_isr_ext[GPIO_WIDTH-1:0] = r_isr;
        w_ier_new = (w_ier_ext & ~w_bmask) | w_wdm;
        w_isr_clr = (w_commit && w_wr_idx == c_idx_isr) ? w_wdm[GPIO_WIDTH-1:0] : '0;
    end

    // r_sync3 is the previous synchronised sample used for edge detection.
    assign w_rise = r_sync2 & ~r_sync3;
    assign irq    = r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync3 <= '0;
            r_ier   <= '0;
            r_isr   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_sync3 <= r_sync2;
            if (w_commit && w_wr_idx == c_idx_ier) r_ier <= w_ier_new[GPIO_WIDTH-1:0];
            // Set wins over a same-cycle write-1-to-clear.
            r_isr <= (r_isr & ~w_isr_clr) | w_rise;
            r_irq <= |(r_isr & r_ier);
        end
    end

    logic w_unused_irq;
    assign w_unused_irq = &{1'b0, w_ier_new};
`endif

    // Address byte-offset bits and any merge bits above GPIO_WIDTH are dropped.
    logic w_unused;
    assign w_unused = &{1'b0, AWADDR[1:0], ARADDR[1:0], w_dout_new, w_dir_new};

endmodule
`default_nettype wire

// File: doc/axi4l_gpio_slave.md
# axi4l_gpio_slave

AXI4-Lite responder exposing a GPIO register bank: the slave end of the `axi4l_interface` bus, driven by the framework's AXI4-Lite master agent. It:
- decodes single-beat reads and writes into a small memory-mapped register file;
- synchronises GPIO inputs;
- drives GPIO outputs and output enables.

It is the DUT the GPIO UVM environment targets.

## Interface
- `addr_width`, 32, AXI address width
- `data_width`, 32, AXI data width (32 only)
- `GPIO_WIDTH`, 32, number of GPIO pins (1..32)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `AWADDR`  in  addr_width  write address
- `AWVALID`/`AWREADY`  in/out  1  write address handshake
- `WDATA`  in  data_width  write data
- `WSTRB`  in  data_width/8  byte strobes
- `WVALID`/`WREADY`  in/out  1  write data handshake
- `BRESP`  out  2  write response
- `BVALID`/`BREADY`  out/in  1  write response handshake
- `ARADDR`  in  addr_width  read address
- `ARVALID`/`ARREADY`  in/out  1  read address handshake
- `RDATA`  out  data_width  read data
- `RRESP`  out  2  read response
- `RVALID`/`RREADY`  out/in  1  read data handshake
- `gpio_in`  in  GPIO_WIDTH  asynchronous pin inputs
- `gpio_out`  out  GPIO_WIDTH  pin output values
- `gpio_oe`  out  GPIO_WIDTH  per-pin output enable, 1 = drive
- `irq`  out  1  level interrupt (only with `GPIO_IRQ_EN`)

## Operation
Register map, word offsets. Decode uses address bits [addr_width-1:2]; bits [1:0] are ignored.
- 0x00 DOUT: RW, drives `gpio_out`
- 0x04 DIR: RW, drives `gpio_oe`
- 0x08 DIN: RO, 2-flop synchronised `gpio_in`
- 0x0C IER and 0x10 ISR: only with `GPIO_IRQ_EN`; otherwise unmapped

Bits at and above GPIO_WIDTH read 0 and ignore writes.

Write path:
- The AW and W channels are captured independently into one holding register each. `AWREADY` is high while the address holder is empty; `WREADY` is high while the data holder is empty.
- Once both holders are full and no response is pending, the register is updated at that edge using `WSTRB` byte enables. Both holders then clear and `BVALID` rises.
- `BRESP` = 2'b00 (OKAY), or 2'b10 (SLVERR) for an unmapped offset or a write to DIN. On SLVERR no state changes.
- `BVALID` holds, with `BRESP` stable, until `BREADY`. While it is held, new AW and W beats may fill the holders but are not committed.

Read path:
- `ARREADY` = !`RVALID`. On the accepting edge, `RDATA`/`RRESP` are registered and `RVALID` rises.
- Unmapped offset → `RDATA` = 0, `RRESP` = 2'b10.
- `RVALID`, `RDATA` and `RRESP` hold until `RREADY`.

Simultaneous read and write:
- The read and write channels are fully independent.
- A read accepted on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset (`rst` low, asynchronous):
  - `AWREADY`, `WREADY` and `ARREADY` = 1 once reset is released. They are 0 while `rst` is low.
  - `BVALID` = `RVALID` = 0; `BRESP` = `RRESP` = 0; `RDATA` = 0.
  - `gpio_out` = 0, `gpio_oe` = 0, synchronisers = 0, IER/ISR = 0, `irq` = 0.
- Reset mid-transaction discards held beats and any pending response.
- Write latency: AW and W both valid in cycle N (holders empty, no pending B) → register and `gpio_out`/`gpio_oe` updated at the end of N, `BVALID` high in N+1. If AW and W arrive in different cycles, the commit happens in the cycle of the later arrival.
- Back-to-back writes with `BREADY` held high: one write every 2 cycles.
- Read latency: `ARVALID` in cycle N with `ARREADY` = 1 → `RVALID` in N+1. With `RREADY` tied high, the next AR is accepted in N+2.
- DIN reflects `gpio_in` 2 cycles after the pin change; a read returns the value sampled at the AR accept edge.

## Configuration
- `GPIO_IRQ_EN` defined:
  - ISR bit i sets on a rising edge of synchronised `gpio_in[i]`.
  - ISR is write-1-to-clear. If a set and a clear hit the same bit in the same cycle, the set wins.
  - IER is RW.
  - `irq` = |(ISR & IER), registered, so it rises 1 cycle after the ISR bit sets.
- `GPIO_IRQ_EN` undefined: no `irq` port, no edge detect. 0x0C and 0x10 return SLVERR.

## Test plan
- Reset then write 0x00 = 0xA5A5_A5A5, `WSTRB` = 4'hF, AW and W in the same cycle → `BVALID` next cycle, `BRESP` = 00, `gpio_out` = 0xA5A5_A5A5. A read of 0x00 returns it with `RRESP` = 00.
- Write W 3 cycles before AW to 0x04 with data 0xFFFF_FFFF, `WSTRB` = 4'b0010 → commit on the AW cycle, `gpio_oe` = 0x0000_FF00.
- Write to 0x08 and read 0x1C → `BRESP` = 10 with DIN unchanged; `RRESP` = 10 with `RDATA` = 0.
- Drive `gpio_in` = 0x1234_5678 → a read of 0x08 after ≥3 cycles returns 0x1234_5678. A same-edge read of 0x00 during a write commit of 0x0000_0001 returns the old value.
- Hold `BREADY` = 0 for 5 cycles, then pulse it; hold `RREADY` = 0 → `BVALID`/`RVALID` and their data stay stable, `ARREADY` stays 0, and the second write is not committed before the B handshake.
- With `GPIO_IRQ_EN`: IER = 0x1, pulse `gpio_in[0]` 0→1 → ISR = 0x1 and `irq` = 1. Write ISR = 0x1 → `irq` = 0 one cycle later. Assert `rst` mid-write → all outputs return to 0.
